// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if
//   Bundles the two buses of the memory-stage responder: the pipeline
//   request/response bus and the word-wide synchronous SRAM bus.
//
//   Pipeline side : req_i, mem_rw_i, mem_size_i, mem_unsigned_i, addr_i,
//                   wdata_i (requests); stall_o, rdata_o, rvalid_o (responses)
//   SRAM side     : sram_en_o, sram_we_o, sram_be_o, sram_addr_o,
//                   sram_wdata_o (strobes); sram_rdata_i (read data, one
//                   cycle after a read strobe)
//
//   modport slave  : the controller
//   modport master : the environment (pipeline + SRAM)
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  // pipeline request
  logic              req_i;
  logic              mem_rw_i;
  logic [1:0]        mem_size_i;
  logic              mem_unsigned_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  // pipeline response
  logic              stall_o;
  logic [31:0]       rdata_o;
  logic              rvalid_o;
  // SRAM bus
  logic              sram_en_o;
  logic              sram_we_o;
  logic [3:0]        sram_be_o;
  logic [ADDR_W-3:0] sram_addr_o;
  logic [31:0]       sram_wdata_o;
  logic [31:0]       sram_rdata_i;

  modport slave (
    input  req_i, mem_rw_i, mem_size_i, mem_unsigned_i, addr_i, wdata_i,
    input  sram_rdata_i,
    output stall_o, rdata_o, rvalid_o,
    output sram_en_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o
  );

  modport master (
    output req_i, mem_rw_i, mem_size_i, mem_unsigned_i, addr_i, wdata_i,
    output sram_rdata_i,
    input  stall_o, rdata_o, rvalid_o,
    input  sram_en_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Memory-stage responder between the pipeline and a word-wide synchronous
//   data SRAM. Generates byte enables and lane-shifted store data, returns
//   sign/zero-extended load data one cycle after the final read, and splits
//   word-crossing accesses into two SRAM accesses with a one-cycle stall.
//
//   Ports:
//     clk   : clock, all state updates on the rising edge
//     rst_n : synchronous active-low reset
//     bus   : data_mem_ctrl_if.slave (pipeline bus + SRAM bus)
module data_mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  data_mem_ctrl_if.slave bus
);

  localparam int WA_W = ADDR_W - 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

  // Everything needed to issue the second half of a split access.
  typedef struct packed {
    logic            rw;
    logic [1:0]      size;
    logic            uns;
    logic [1:0]      off;
    logic [WA_W-1:0] addr;
    logic [3:0]      be;
    logic [31:0]     wdata;
  } split_desc_t;

  // Load whose final read has been issued and whose data returns next cycle.
  typedef struct packed {
    logic       valid;
    logic [1:0] off;
    logic [1:0] size;
    logic       uns;
    logic       split;
  } pend_desc_t;

  state_e      state, state_nxt;
  split_desc_t desc;
  pend_desc_t  pend;
  logic [31:0] lo_buf;

  // Request decode
  logic [1:0]      off;
  logic [WA_W-1:0] wa;
  logic [WA_W-1:0] wa_next;
  logic            is_half;
  logic            is_word;
  logic            split_req;
  logic [3:0]      mask;
  logic [7:0]      be_wide;
  logic [63:0]     wdata_wide;
  logic            accept;
  logic            accept_split;
  logic            last_load_read;

  // NOTE: every variable assigned in an always_comb gets a default at the top
  // of the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    off        = bus.addr_i[1:0];
    wa         = bus.addr_i[ADDR_W-1:2];
    wa_next    = wa + WA_W'(1);              // wraps at the top of the space
    is_word    = bus.mem_size_i[1];          // size 3 behaves as word
    is_half    = (bus.mem_size_i == 2'd1);
    mask       = is_word ? 4'b1111 : (is_half ? 4'b0011 : 4'b0001);
    be_wide    = {4'b0000, mask} << off;
    wdata_wide = {32'b0, bus.wdata_i} << {off, 3'b000};
    split_req  = (is_half && off == 2'd3) || (is_word && off != 2'd0);
    // Requests are ignored while reset is held and while finishing a split.
    accept       = rst_n && bus.req_i && (state == ST_IDLE);
    accept_split = accept && split_req;
    // Cycle issuing the read whose data completes a load.
    last_load_read = (accept && !bus.mem_rw_i && !split_req) ||
                     (rst_n && state == ST_SPLIT && !desc.rw);
  end

  // FSM: state register
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept_split) state_nxt = ST_SPLIT;
      ST_SPLIT: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs. The first (or only) access always uses the low lane halves;
  // the second access of a split replays the registered high halves.
  always_comb begin
    bus.sram_en_o    = 1'b0;
    bus.sram_we_o    = 1'b0;
    bus.sram_be_o    = 4'b0000;
    bus.sram_addr_o  = '0;
    bus.sram_wdata_o = 32'b0;
    bus.stall_o      = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          if (bus.req_i) begin
            bus.sram_en_o    = 1'b1;
            bus.sram_we_o    = bus.mem_rw_i;
            bus.sram_be_o    = be_wide[3:0];
            bus.sram_addr_o  = wa;
            bus.sram_wdata_o = wdata_wide[31:0];
            bus.stall_o      = split_req;
          end
        end
        ST_SPLIT: begin
          bus.sram_en_o    = 1'b1;
          bus.sram_we_o    = desc.rw;
          bus.sram_be_o    = desc.be;
          bus.sram_addr_o  = desc.addr;
          bus.sram_wdata_o = desc.wdata;
        end
        default: ;
      endcase
    end
  end

  // Pending-load tracking. Only the valid bit needs a reset value; the
  // remaining fields are qualified by it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend.valid <= last_load_read;
      if (state == ST_SPLIT) begin
        pend.off   <= desc.off;
        pend.size  <= desc.size;
        pend.uns   <= desc.uns;
        pend.split <= 1'b1;
      end else begin
        pend.off   <= off;
        pend.size  <= bus.mem_size_i;
        pend.uns   <= bus.mem_unsigned_i;
        pend.split <= 1'b0;
      end
    end
  end

  // NOTE: pure data holders (split descriptor, low read buffer) carry no
  // reset; they are always written before the control state that uses them.
  always_ff @(posedge clk) begin
    if (accept_split) begin
      desc.rw    <= bus.mem_rw_i;
      desc.size  <= bus.mem_size_i;
      desc.uns   <= bus.mem_unsigned_i;
      desc.off   <= off;
      desc.addr  <= wa_next;
      desc.be    <= be_wide[7:4];
      desc.wdata <= wdata_wide[63:32];
    end
    if (state == ST_SPLIT) lo_buf <= bus.sram_rdata_i;
  end

  // Load return: realign the (one or two) words and extend to 32 bits.
  logic [31:0] rd_shift;

  always_comb begin
    rd_shift = pend.split
             ? 32'({bus.sram_rdata_i, lo_buf} >> {pend.off, 3'b000})
             : 32'({32'b0, bus.sram_rdata_i} >> {pend.off, 3'b000});
    bus.rvalid_o = rst_n && pend.valid;
    bus.rdata_o  = 32'b0;
    if (bus.rvalid_o) begin
      if (pend.size[1])
        bus.rdata_o = rd_shift;
      else if (pend.size[0])
        bus.rdata_o = {{16{rd_shift[15] & ~pend.uns}}, rd_shift[15:0]};
      else
        bus.rdata_o = {{24{rd_shift[7] & ~pend.uns}}, rd_shift[7:0]};
    end
  end

endmodule
